// File: rtl/move_scheduler_pkg.sv
// move_scheduler_pkg: shared opcodes, key codes and FSM state type for the move scheduler.
package move_scheduler_pkg;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LEFT  = 3'd1,
    OP_RIGHT = 3'd2,
    OP_ROT   = 3'd3,
    OP_DOWN  = 3'd4,
    OP_LOCK  = 3'd5
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_LOCK} state_t;
  localparam logic [7:0] KEY_LEFT  = 8'd97;
  localparam logic [7:0] KEY_RIGHT = 8'd100;
  localparam logic [7:0] KEY_ROT   = 8'd119;
  localparam logic [7:0] KEY_DOWN  = 8'd115;
  function automatic op_t key_op(input logic [7:0] code);
    return code == KEY_LEFT  ? OP_LEFT  :
           code == KEY_RIGHT ? OP_RIGHT :
           code == KEY_ROT   ? OP_ROT   :
           code == KEY_DOWN  ? OP_DOWN  : OP_NONE;
  endfunction
endpackage

// File: rtl/move_scheduler_cmd_fifo.sv
// cmd_fifo: small command queue with drop-on-full push, guarded pop and synchronous flush.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = wp == {~rp[AW], rp[AW-1:0]};
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: queues key moves and gravity ticks, issues them to the board engine one at a time.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       tick,
  input  logic       halt,
  output logic       mv_req,
  output logic [2:0] mv_op,
  input  logic       mv_ack,
  input  logic       mv_ok,
  output logic [7:0] left_cnt,
  output logic [7:0] right_cnt,
  output logic [7:0] rot_cnt,
  output logic       err
);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  state_t state, state_d;
  op_t op, op_d;
  logic [TW-1:0] tmo, tmo_d;
  logic [2:0] fifo_dout;
  logic grav, grav_d, req_d, err_d, pop, flush, key_hit, fifo_full, fifo_empty, lock_go, done_ok;
  assign key_hit = key_valid && key_op(key_code) != OP_NONE;
  assign lock_go = state == S_WAIT && !mv_ok && op == OP_DOWN;
  assign done_ok = state == S_WAIT && mv_ack && mv_ok;
  assign mv_op   = op;
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(key_hit && (!fifo_full || pop)), .pop(pop), .flush(flush),
    .din(key_op(key_code)), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );
  always_comb begin
    state_d = state;
    op_d    = op;
    req_d   = mv_req;
    tmo_d   = tmo;
    err_d   = err;
    grav_d  = grav | tick;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state)
      S_IDLE:
        if (!halt && (grav || !fifo_empty)) begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
          grav_d  = tick;
          op_d    = grav ? OP_DOWN : op_t'(fifo_dout);
          pop     = !grav;
        end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT, S_LOCK:
        // LOCK is entered with mv_req low so the engine sees a fresh request edge
        if (state == S_LOCK && !mv_req) begin
          req_d = 1'b1;
          tmo_d = '0;
        end else if (mv_ack) begin
          req_d   = 1'b0;
          flush   = state == S_LOCK;
          state_d = lock_go ? S_LOCK : S_IDLE;
          op_d    = lock_go ? OP_LOCK : op;
        end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else tmo_d = tmo + TW'(1);
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      op        <= OP_NONE;
      mv_req    <= 1'b0;
      tmo       <= '0;
      err       <= 1'b0;
      grav      <= 1'b0;
      left_cnt  <= '0;
      right_cnt <= '0;
      rot_cnt   <= '0;
    end else begin
      state  <= state_d;
      op     <= op_d;
      mv_req <= req_d;
      tmo    <= tmo_d;
      err    <= err_d;
      grav   <= grav_d;
      if (done_ok && op == OP_LEFT && left_cnt != 8'hff) left_cnt <= left_cnt + 8'd1;
      if (done_ok && op == OP_RIGHT && right_cnt != 8'hff) right_cnt <= right_cnt + 8'd1;
      if (done_ok && op == OP_ROT && rot_cnt != 8'hff) rot_cnt <= rot_cnt + 8'd1;
    end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed and randomized checks of move_scheduler against a queue-based model.
module tb_move_scheduler;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0, key_valid = 0, tick = 0, halt = 0, mv_ack = 0, mv_ok = 0;
  logic [7:0] key_code = 0;
  logic mv_req, err;
  logic [2:0] mv_op;
  logic [7:0] left_cnt, right_cnt, rot_cnt;
  int checks = 0, errors = 0;
  int q[$];
  bit m_grav = 0, m_req = 0, m_err = 0;
  int m_op = 0, m_ph = 0, m_age = 0;
  int m_cnt[3] = '{0, 0, 0};
  int hi;

  move_scheduler #(.FIFO_DEPTH(4), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .tick(tick), .halt(halt),
    .mv_req(mv_req), .mv_op(mv_op), .mv_ack(mv_ack), .mv_ok(mv_ok),
    .left_cnt(left_cnt), .right_cnt(right_cnt), .rot_cnt(rot_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kop(input logic [7:0] c);
    case (c)
      8'd97:   return 1;
      8'd100:  return 2;
      8'd119:  return 3;
      8'd115:  return 4;
      default: return 0;
    endcase
  endfunction

  // Model phases: 0 free, 1 just issued, 2 awaiting ack, 3 lock about to be raised, 4 lock awaiting ack
  always @(posedge clk or negedge rst_n) begin
    int k;
    bit fl;
    if (!rst_n) begin
      q.delete();
      m_grav = 0; m_req = 0; m_err = 0; m_op = 0; m_ph = 0; m_age = 0;
      m_cnt = '{0, 0, 0};
    end else begin
      k = key_valid ? kop(key_code) : 0;
      fl = 0;
      if (m_ph == 0) begin
        if (!halt && m_grav) begin
          m_op = 4; m_grav = 0; m_req = 1; m_ph = 1;
        end else if (!halt && q.size() > 0) begin
          m_op = q.pop_front(); m_req = 1; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        m_ph = 2; m_age = 0;
      end else if (m_ph == 3) begin
        m_req = 1; m_ph = 4; m_age = 0;
      end else if (mv_ack) begin
        m_req = 0;
        if (m_ph == 4) begin
          fl = 1; m_ph = 0;
        end else if (mv_ok) begin
          if (m_op <= 3) m_cnt[m_op-1] = m_cnt[m_op-1] == 255 ? 255 : m_cnt[m_op-1] + 1;
          m_ph = 0;
        end else if (m_op == 4) begin
          m_op = 5; m_ph = 3;
        end else m_ph = 0;
      end else begin
        m_age++;
        if (m_age == TO) begin
          m_err = 1; m_req = 0; m_ph = 0;
        end
      end
      if (tick) m_grav = 1;
      if (fl) q.delete();
      else if (k != 0 && q.size() < 4) q.push_back(k);
    end
  end

  always @(negedge clk)
    if (rst_n) begin
      chk("mv_req", mv_req, m_req);
      chk("mv_op", mv_op, m_op);
      chk("err", err, m_err);
      chk("left_cnt", left_cnt, m_cnt[0]);
      chk("right_cnt", right_cnt, m_cnt[1]);
      chk("rot_cnt", rot_cnt, m_cnt[2]);
    end

  task automatic key(input logic [7:0] c);
    key_valid = 1; key_code = c;
    @(negedge clk);
    key_valid = 0;
  endtask

  task automatic pulse_ack(input bit ok);
    mv_ack = 1; mv_ok = ok;
    @(negedge clk);
    mv_ack = 0; mv_ok = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mv_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req", mv_req, 1);
  endtask

  initial begin
    int codes[6] = '{97, 100, 97, 100, 119, 97};
    int exp4[4] = '{1, 2, 1, 2};
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_req", mv_req, 0);
    chk("rst_err", err, 0);
    chk("rst_op", mv_op, 0);
    chk("rst_cnts", left_cnt + right_cnt + rot_cnt, 0);
    // single LEFT, acked 3 cycles after request rises
    key(97);
    wait_req();
    hi = 1;
    repeat (3) begin @(negedge clk); hi += mv_req; end
    pulse_ack(1);
    chk("s1_op", mv_op, 1);
    chk("s1_req_cycles", hi, 4);
    chk("s1_req_fell", mv_req, 0);
    chk("s1_left", left_cnt, 1);
    // gravity beats a key arriving in the same cycle
    tick = 1; key_valid = 1; key_code = 100;
    @(negedge clk);
    tick = 0; key_valid = 0;
    wait_req();
    chk("s2_first_down", mv_op, 4);
    @(negedge clk); pulse_ack(1);
    wait_req();
    chk("s2_then_right", mv_op, 2);
    @(negedge clk); pulse_ack(1);
    chk("s2_right", right_cnt, 1);
    // failed DOWN -> LOCK, queue flushed afterwards
    tick = 1; @(negedge clk); tick = 0;
    wait_req();
    chk("s3_down", mv_op, 4);
    key(97); key(100);
    pulse_ack(0);
    chk("s3_req_dropped", mv_req, 0);
    chk("s3_lock_op", mv_op, 5);
    wait_req();
    chk("s3_lock_issued", mv_op, 5);
    @(negedge clk); pulse_ack(1);
    hi = 0;
    repeat (6) begin @(negedge clk); hi += mv_req; end
    chk("s3_fifo_flushed", hi, 0);
    chk("s3_left_same", left_cnt, 1);
    // overfill the queue while a request is stalled
    key(119);
    wait_req();
    chk("s4_rot", mv_op, 3);
    foreach (codes[i]) key(codes[i]);
    pulse_ack(1);
    foreach (exp4[i]) begin
      wait_req();
      chk("s4_order", mv_op, exp4[i]);
      @(negedge clk); pulse_ack(1);
    end
    hi = 0;
    repeat (6) begin @(negedge clk); hi += mv_req; end
    chk("s4_two_dropped", hi, 0);
    // ack timeout
    key(97);
    wait_req();
    hi = 1;
    for (int n = 0; mv_req && n < 40; n++) begin @(negedge clk); hi += mv_req; end
    chk("s5_req_high_cycles", hi, 17);
    chk("s5_err", err, 1);
    chk("s5_req_low", mv_req, 0);
    key(100);
    wait_req();
    chk("s5_idle_again", mv_op, 2);
    @(negedge clk); pulse_ack(1);
    chk("s5_err_sticky", err, 1);
    // counter saturation
    rst_n = 0; @(negedge clk); rst_n = 1;
    chk("s6_err_cleared", err, 0);
    repeat (300) begin
      key(119);
      wait_req();
      @(negedge clk); pulse_ack(1);
    end
    chk("s6_rot_sat", rot_cnt, 255);
    chk("s6_left_zero", left_cnt, 0);
    // randomized traffic, then reset mid-request, then slow-ack traffic
    for (int c = 0; c < 4000; c++) begin
      key_valid = $urandom_range(3) == 0;
      case ($urandom_range(4))
        0: key_code = 97;
        1: key_code = 100;
        2: key_code = 119;
        3: key_code = 115;
        default: key_code = 8'($urandom_range(255));
      endcase
      tick = $urandom_range(9) == 0;
      if ($urandom_range(49) == 0) halt = ~halt;
      mv_ack = c >= 2000 ? $urandom_range(29) == 0 : $urandom_range(2) == 0;
      mv_ok = 1'($urandom_range(1));
      @(negedge clk);
      if (c == 1999) begin
        key_valid = 0; tick = 1; halt = 0; mv_ack = 0; mv_ok = 0;
        @(negedge clk);
        tick = 0;
        wait_req();
        #2 rst_n = 0;
        #1 chk("async_reset_req", mv_req, 0);
        chk("async_reset_err", err, 0);
        @(negedge clk);
        rst_n = 1;
      end
    end
    key_valid = 0; tick = 0; halt = 0; mv_ack = 0; mv_ok = 0;
    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
